// File: rtl/ysyx_041461_clint_pkg.sv
// Shared CLINT definitions: register offsets, FSM state encoding, byte-merge helper.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package ysyx_041461_clint_pkg;

   localparam logic [63:0] CLINT_MSIP_OFF     = 64'h0000_0000_0000_0000;
   localparam logic [63:0] CLINT_MTIMECMP_OFF = 64'h0000_0000_0000_4000;
   localparam logic [63:0] CLINT_MTIME_OFF    = 64'h0000_0000_0000_BFF8;

   typedef enum logic {
      CLINT_IDLE = 1'b0,
      CLINT_RESP = 1'b1
   } clint_state_t;

   // Replace the bytes of i_old selected by i_mask with the bytes of i_new.
   function automatic logic [63:0] clint_wmerge(input logic [63:0] i_old,
                                                input logic [63:0] i_new,
                                                input logic [7:0]  i_mask);
      logic [63:0] w_res;
      w_res = i_old;
      for (int b = 0; b < 8; b++) begin
         if (i_mask[b]) w_res[8*b +: 8] = i_new[8*b +: 8];
      end
      return w_res;
   endfunction

endpackage

// File: rtl/ysyx_041461_clint_timer.sv
// mtime counter with prescaler, byte-masked write merged with the tick, and timer_irq compare.
// Latency: mtime updates at the write/tick edge; timer_irq lags register values by one cycle.
// Backpressure: none; the prescaler runs freely regardless of bus activity.
module ysyx_041461_clint_timer
   import ysyx_041461_clint_pkg::*;
#(
   parameter int unsigned TICK_DIV = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_wen,
   input  logic [63:0] i_wdata,
   input  logic [7:0]  i_wmask,
   input  logic [63:0] i_mtimecmp,
   output logic [63:0] o_mtime,
   output logic        o_timer_irq
);

   localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

   logic [15:0] r_presc;
   logic [63:0] r_mtime;
   logic        r_timer_irq;
   logic        w_tick;
   logic [63:0] w_mtime_inc;
   logic [63:0] w_mtime_base;

   assign w_tick       = (r_presc == PRESC_MAX);
   assign w_mtime_inc  = r_mtime + 64'd1;
   // A write on a tick edge merges into the incremented value, so the tick itself is consumed.
   assign w_mtime_base = w_tick ? w_mtime_inc : r_mtime;

   // Prescaler counts 0..TICK_DIV-1 and wraps on the tick.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         r_presc <= '0;
      else if (w_tick) r_presc <= '0;
      else             r_presc <= r_presc + 16'd1;
   end

   // mtime: masked write wins over the plain increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         r_mtime <= '0;
      else if (i_wen)  r_mtime <= clint_wmerge(w_mtime_base, i_wdata, i_wmask);
      else if (w_tick) r_mtime <= w_mtime_inc;
   end

   // Registered unsigned compare of the current register values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_timer_irq <= 1'b0;
      else     r_timer_irq <= (r_mtime >= i_mtimecmp);
   end

   assign o_mtime     = r_mtime;
   assign o_timer_irq = r_timer_irq;

endmodule

// File: rtl/ysyx_041461_clint.sv
// Core-local interruptor: memory-mapped msip/mtimecmp/mtime on a valid/ready request/response pair.
// Latency: response valid one cycle after acceptance; one access per two cycles.
// Backpressure: while a response waits for resp_ready, req_ready is low and no request is taken.
module ysyx_041461_clint
   import ysyx_041461_clint_pkg::*;
#(
   parameter logic [63:0] BASE     = 64'h0000_0000_0200_0000,
   parameter int unsigned TICK_DIV = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   input  logic [7:0]  req_wmask,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_rdata,
   output logic        resp_err,
   output logic        timer_irq,
   output logic        soft_irq
);

   clint_state_t r_state;
   logic         r_msip;
   logic [63:0]  r_mtimecmp;
   logic [63:0]  r_resp_rdata;
   logic         r_resp_err;

   logic         w_accept;
   logic [63:0]  w_off;
   logic         w_aligned;
   logic         w_hit_msip;
   logic         w_hit_cmp;
   logic         w_hit_mtime;
   logic         w_err;
   logic         w_wr_ok;
   logic [63:0]  w_rdata;
   logic [63:0]  w_mtime;

   assign w_accept    = (r_state == CLINT_IDLE) && req_valid;
   assign w_off       = req_addr - BASE;
   assign w_aligned   = (req_addr[2:0] == 3'b000);
   assign w_hit_msip  = w_aligned && (w_off == CLINT_MSIP_OFF);
   assign w_hit_cmp   = w_aligned && (w_off == CLINT_MTIMECMP_OFF);
   assign w_hit_mtime = w_aligned && (w_off == CLINT_MTIME_OFF);
   assign w_err       = !(w_hit_msip || w_hit_cmp || w_hit_mtime);
   assign w_wr_ok     = w_accept && req_wen && !w_err;

   // Read mux over pre-edge register values.
   always_comb begin
      w_rdata = '0;
      if (w_hit_msip)      w_rdata = {63'd0, r_msip};
      else if (w_hit_cmp)  w_rdata = r_mtimecmp;
      else if (w_hit_mtime) w_rdata = w_mtime;
   end

   ysyx_041461_clint_timer #(
      .TICK_DIV (TICK_DIV)
   ) u_timer (
      .clk         (clk),
      .rst         (rst),
      .i_wen       (w_wr_ok && w_hit_mtime),
      .i_wdata     (req_wdata),
      .i_wmask     (req_wmask),
      .i_mtimecmp  (r_mtimecmp),
      .o_mtime     (w_mtime),
      .o_timer_irq (timer_irq)
   );

   // Request/response FSM; the response is captured at acceptance and held until taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= CLINT_IDLE;
         r_resp_rdata <= '0;
         r_resp_err   <= 1'b0;
      end else begin
         case (r_state)
            CLINT_IDLE: begin
               if (req_valid) begin
                  r_state      <= CLINT_RESP;
                  r_resp_err   <= w_err;
                  r_resp_rdata <= (req_wen || w_err) ? 64'd0 : w_rdata;
               end
            end
            CLINT_RESP: begin
               if (resp_ready) r_state <= CLINT_IDLE;
            end
            default: r_state <= CLINT_IDLE;
         endcase
      end
   end

   // msip holds bit 0 only; the write applies when byte 0 is enabled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                  r_msip <= 1'b0;
      else if (w_wr_ok && w_hit_msip && req_wmask[0]) r_msip <= req_wdata[0];
   end

   // mtimecmp with byte-masked writes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                     r_mtimecmp <= '1;
      else if (w_wr_ok && w_hit_cmp) r_mtimecmp <= clint_wmerge(r_mtimecmp, req_wdata, req_wmask);
   end

   assign req_ready  = (r_state == CLINT_IDLE);
   assign resp_valid = (r_state == CLINT_RESP);
   assign resp_rdata = r_resp_rdata;
   assign resp_err   = r_resp_err;
   assign soft_irq   = r_msip;

endmodule

// File: tb/tb_ysyx_041461_clint.sv
// Bench for ysyx_041461_clint: two instances (TICK_DIV=1 and 4) share one request stream.
// Latency: the reference model advances once per clock edge and is compared 1 time unit after it.
// Backpressure: resp_ready is driven low for directed and random stall windows.
module tb_ysyx_041461_clint;

   localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;
   localparam logic [63:0] A_MSIP  = BASE + 64'h0000;
   localparam logic [63:0] A_CMP   = BASE + 64'h4000;
   localparam logic [63:0] A_MTIME = BASE + 64'hBFF8;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_wen;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic [7:0]  req_wmask;
   logic        resp_ready;

   logic        rdy   [2];
   logic        rvld  [2];
   logic [63:0] rdata [2];
   logic        rerr  [2];
   logic        tirq  [2];
   logic        sirq  [2];

   int n_tests = 0;
   int n_fail  = 0;

   ysyx_041461_clint #(.BASE(BASE), .TICK_DIV(1)) dut1 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]), .req_wen(req_wen),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
      .resp_valid(rvld[0]), .resp_ready(resp_ready), .resp_rdata(rdata[0]), .resp_err(rerr[0]),
      .timer_irq(tirq[0]), .soft_irq(sirq[0]));

   ysyx_041461_clint #(.BASE(BASE), .TICK_DIV(4)) dut4 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]), .req_wen(req_wen),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
      .resp_valid(rvld[1]), .resp_ready(resp_ready), .resp_rdata(rdata[1]), .resp_err(rerr[1]),
      .timer_irq(tirq[1]), .soft_irq(sirq[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: architectural registers, edge count since reset, pending response.
   int unsigned DIVS [2] = '{1, 4};
   int          m_edges;
   bit          m_resp;
   bit          m_err;
   bit          m_msip;
   logic [63:0] m_cmp;
   logic [63:0] m_mt    [2];
   logic [63:0] m_rdata [2];
   bit          m_irq   [2];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_edges = 0; m_resp = 0; m_err = 0; m_msip = 0; m_cmp = '1;
      for (int d = 0; d < 2; d++) begin
         m_mt[d] = '0; m_rdata[d] = '0; m_irq[d] = 0;
      end
   endtask

   function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n, input logic [7:0] m);
      logic [63:0] r;
      r = o;
      for (int b = 0; b < 8; b++) if (m[b]) r[8*b +: 8] = n[8*b +: 8];
      return r;
   endfunction

   task automatic check_outputs();
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("req_ready[%0d]", d),  rdy[d],  !m_resp);
         chk($sformatf("resp_valid[%0d]", d), rvld[d], m_resp);
         if (m_resp) begin
            chk($sformatf("resp_rdata[%0d]", d), rdata[d], m_rdata[d]);
            chk($sformatf("resp_err[%0d]", d),   rerr[d],  m_err);
         end
         chk($sformatf("timer_irq[%0d]", d), tirq[d], m_irq[d]);
         chk($sformatf("soft_irq[%0d]", d),  sirq[d], m_msip);
      end
   endtask

   // Advance the model over one clock edge using the inputs currently driven, then compare.
   task automatic edge_step();
      bit          acc, tk, aligned, h_ms, h_cmp, h_mt, err;
      logic [63:0] off, base_v;
      logic [63:0] nmt [2];
      bit          nirq [2];
      m_edges++;
      acc     = !m_resp && req_valid;
      off     = req_addr - BASE;
      aligned = (req_addr % 8) == 0;
      h_ms    = aligned && off == 64'h0;
      h_cmp   = aligned && off == 64'h4000;
      h_mt    = aligned && off == 64'hBFF8;
      err     = !(h_ms || h_cmp || h_mt);
      for (int d = 0; d < 2; d++) begin
         nirq[d] = m_mt[d] >= m_cmp;
         tk      = (m_edges % DIVS[d]) == 0;
         base_v  = tk ? m_mt[d] + 64'd1 : m_mt[d];
         nmt[d]  = (acc && req_wen && !err && h_mt) ? merge(base_v, req_wdata, req_wmask) : base_v;
      end
      if (acc) begin
         m_err = err;
         for (int d = 0; d < 2; d++)
            m_rdata[d] = (req_wen || err) ? 64'd0 :
                         h_ms ? {63'd0, m_msip} : h_cmp ? m_cmp : m_mt[d];
         if (req_wen && !err && h_ms && req_wmask[0]) m_msip = req_wdata[0];
         if (req_wen && !err && h_cmp) m_cmp = merge(m_cmp, req_wdata, req_wmask);
         m_resp = 1;
      end else if (m_resp && resp_ready) begin
         m_resp = 0;
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         m_mt[d]  = nmt[d];
         m_irq[d] = nirq[d];
      end
      check_outputs();
   endtask

   // One complete access from idle: accept, optional stall, handshake. Returns the response data.
   task automatic access(input bit wen, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [7:0] mask, input int stall,
                         output logic [63:0] o_rd0, output logic [63:0] o_rd1);
      req_valid = 1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_wmask = mask;
      resp_ready = (stall == 0);
      edge_step();
      o_rd0 = rdata[0]; o_rd1 = rdata[1];
      req_valid = 0;
      repeat (stall) edge_step();
      resp_ready = 1;
      edge_step();
   endtask

   initial begin
      logic [63:0] rd0, rd1;
      logic [63:0] held;
      logic [63:0] addrs [5];
      rst = 1; req_valid = 0; req_wen = 0; req_addr = '0; req_wdata = '0; req_wmask = '0;
      resp_ready = 1;
      model_reset();
      #12;
      for (int d = 0; d < 2; d++) begin
         chk("rst_req_ready", rdy[d], 1'b1);
         chk("rst_resp_valid", rvld[d], 1'b0);
         chk("rst_resp_rdata", rdata[d], 64'd0);
         chk("rst_resp_err", rerr[d], 1'b0);
      end
      #10 rst = 0;

      // Idle 10 edges, then read mtime on edge 11.
      repeat (10) edge_step();
      access(0, A_MTIME, '0, 8'h00, 0, rd0, rd1);
      chk("mtime_after_10_div1", rd0, 64'd10);
      chk("mtime_after_10_div4", rd1, 64'd2);

      // mtimecmp=20: irq rises one cycle after mtime reaches 20, then falls after raising cmp.
      access(1, A_CMP, 64'd20, 8'hFF, 0, rd0, rd1);
      repeat (12) edge_step();
      chk("irq_high_div1", tirq[0], 1'b1);
      access(1, A_CMP, '1, 8'hFF, 0, rd0, rd1);
      repeat (3) edge_step();

      // Backpressure: read held 5 cycles while another request is already offered.
      req_valid = 1; req_wen = 0; req_addr = A_CMP; resp_ready = 0;
      edge_step();
      held = rdata[0];
      req_addr = A_MSIP;
      repeat (5) edge_step();
      chk("held_rdata", rdata[0], held);
      chk("held_req_ready", rdy[0], 1'b0);
      resp_ready = 1;
      edge_step();
      edge_step();
      chk("queued_accept", rvld[0], 1'b1);
      req_valid = 0;
      edge_step();

      // Error accesses change nothing.
      access(0, BASE + 64'h4004, '0, 8'h00, 0, rd0, rd1);
      access(0, BASE + 64'h1000, '0, 8'h00, 0, rd0, rd1);
      access(1, BASE + 64'h4004, 64'h5, 8'hFF, 0, rd0, rd1);
      access(1, BASE + 64'h0004, 64'h1, 8'hFF, 0, rd0, rd1);
      access(0, A_CMP, '0, 8'h00, 0, rd0, rd1);
      chk("cmp_unchanged", rd0, 64'hFFFF_FFFF_FFFF_FFFF);

      // Byte write to mtime on a tick edge merges with mtime+1.
      access(1, A_MTIME, 64'h1233, 8'hFF, 0, rd0, rd1);
      access(1, A_MTIME, 64'h00FF, 8'h01, 0, rd0, rd1);
      access(0, A_MTIME, '0, 8'h00, 0, rd0, rd1);
      chk("mtime_merge", rd0, 64'h1300);
      access(1, A_MSIP, 64'hFFFF_FFFF_0000_0003, 8'h01, 0, rd0, rd1);
      access(1, A_MSIP, 64'h0, 8'h00, 1, rd0, rd1);
      access(0, A_MSIP, '0, 8'h00, 0, rd0, rd1);
      chk("msip_read", rd0, 64'h1);

      // mtime wrap and compare across it.
      access(1, A_MTIME, '1, 8'hFF, 0, rd0, rd1);
      repeat (6) edge_step();
      access(1, A_CMP, 64'd3, 8'hFF, 0, rd0, rd1);
      repeat (16) edge_step();

      // Reset while a response is pending drops it.
      req_valid = 1; req_wen = 0; req_addr = A_MTIME; resp_ready = 0;
      edge_step();
      req_valid = 0;
      rst = 1;
      #2;
      model_reset();
      chk("midrst_resp_valid", rvld[0], 1'b0);
      chk("midrst_req_ready", rdy[1], 1'b1);
      rst = 0;
      resp_ready = 1;
      repeat (3) edge_step();

      // Randomized accesses checked against the model.
      addrs[0] = A_MSIP; addrs[1] = A_CMP; addrs[2] = A_MTIME;
      for (int i = 0; i < 60; i++) begin
         addrs[3] = BASE + 64'h4004;
         addrs[4] = BASE + {48'd0, 13'($urandom), 3'b000};
         access(1'($urandom_range(0, 1)), addrs[$urandom_range(0, 4)],
                {$urandom, $urandom} >> $urandom_range(0, 63), 8'($urandom),
                int'($urandom_range(0, 3)), rd0, rd1);
         repeat ($urandom_range(0, 2)) edge_step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
